// File: rtl/w5300_bus_ctrl_if.sv
// w5300_bus_ctrl_if: requester handshake (ports A and B) plus W5300 pin bundle.
// The slave modport is the bus sequencer; master is the requester/W5300 side.
interface w5300_bus_ctrl_if;
    logic       a_req;
    logic       a_rnw;
    logic [9:0] a_addr;
    logic [7:0] a_wdata;
    logic       a_ack;
    logic       b_req;
    logic       b_rnw;
    logic [9:0] b_addr;
    logic [7:0] b_wdata;
    logic       b_ack;
    logic [7:0] rdata;
    logic       irq;
    logic [9:0] w_addr;
    logic       w_cs_n;
    logic       w_rd_n;
    logic       w_wr_n;
    logic [7:0] w_d_out;
    logic       w_d_oe;
    logic [7:0] w_d_in;
    logic       w_int_n;

    modport slave (
        input  a_req, a_rnw, a_addr, a_wdata,
        input  b_req, b_rnw, b_addr, b_wdata,
        input  w_d_in, w_int_n,
        output a_ack, b_ack, rdata, irq,
        output w_addr, w_cs_n, w_rd_n, w_wr_n, w_d_out, w_d_oe
    );

    modport master (
        output a_req, a_rnw, a_addr, a_wdata,
        output b_req, b_rnw, b_addr, b_wdata,
        output w_d_in, w_int_n,
        input  a_ack, b_ack, rdata, irq,
        input  w_addr, w_cs_n, w_rd_n, w_wr_n, w_d_out, w_d_oe
    );
endinterface

// File: rtl/w5300_bus_ctrl.sv
// w5300_bus_ctrl: two-port bus sequencer for the W5300 8-bit host port.
// Each access runs IDLE -> SETUP -> STROBE -> HOLD -> IDLE; every pin is a flop.
// Optional feature: define W5300_BUS_CTRL_RR_EN for round-robin arbitration;
// otherwise port A has fixed priority over port B.
module w5300_bus_ctrl #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic clk,
    input  logic rst_n,
    w5300_bus_ctrl_if.slave bus
);

    localparam int unsigned MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               grant_b_q, grant_b_d;
    logic               rnw_q, rnw_d;
    logic [9:0]         addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               cs_n_q, cs_n_d;
    logic               rd_n_q, rd_n_d;
    logic               wr_n_q, wr_n_d;
    logic               d_oe_q, d_oe_d;
    logic               ack_a_q, ack_a_d;
    logic               ack_b_q, ack_b_d;
    logic               int_s1_q, int_s2_q;
    logic               grant_evt;
    logic               pick_b;

    assign grant_evt = (state_q == IDLE) && (bus.a_req || bus.b_req);

`ifdef W5300_BUS_CTRL_RR_EN
    logic prefer_b_q;

    // Round-robin pointer: whichever port was just granted loses the next tie.
    always_ff @(posedge clk) begin
        if (!rst_n)         prefer_b_q <= 1'b0;
        else if (grant_evt) prefer_b_q <= !pick_b;
    end

    assign pick_b = bus.b_req && (!bus.a_req || prefer_b_q);
`else
    assign pick_b = !bus.a_req;
`endif

    // Next-state logic; pin values are derived from the next state so they leave flops.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_b_d = grant_b_q;
        rnw_d     = rnw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_evt) begin
                    grant_b_d = pick_b;
                    rnw_d     = pick_b ? bus.b_rnw   : bus.a_rnw;
                    addr_d    = pick_b ? bus.b_addr  : bus.a_addr;
                    wdata_d   = pick_b ? bus.b_wdata : bus.a_wdata;
                    state_d   = SETUP;
                    cnt_d     = CNT_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = CNT_W'(STROBE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                    if (rnw_q) rdata_d = bus.w_d_in;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        cs_n_d  = (state_d == IDLE);
        rd_n_d  = !((state_d == STROBE) && rnw_d);
        wr_n_d  = !((state_d == STROBE) && !rnw_d);
        d_oe_d  = (state_d != IDLE) && !rnw_d;
        ack_a_d = (state_d == HOLD) && (cnt_d == '0) && !grant_b_d;
        ack_b_d = (state_d == HOLD) && (cnt_d == '0) && grant_b_d;
    end

    // State, latched transaction and registered pin outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            grant_b_q <= 1'b0;
            rnw_q     <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            d_oe_q    <= 1'b0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_b_q <= grant_b_d;
            rnw_q     <= rnw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            d_oe_q    <= d_oe_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
        end
    end

    // Two-flop synchroniser for the asynchronous, active-low interrupt pin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            int_s1_q <= 1'b0;
            int_s2_q <= 1'b0;
        end else begin
            int_s1_q <= !bus.w_int_n;
            int_s2_q <= int_s1_q;
        end
    end

    assign bus.w_addr  = addr_q;
    assign bus.w_d_out = wdata_q;
    assign bus.w_cs_n  = cs_n_q;
    assign bus.w_rd_n  = rd_n_q;
    assign bus.w_wr_n  = wr_n_q;
    assign bus.w_d_oe  = d_oe_q;
    assign bus.a_ack   = ack_a_q;
    assign bus.b_ack   = ack_b_q;
    assign bus.rdata   = rdata_q;
    assign bus.irq     = int_s2_q;

endmodule

// File: tb/tb_w5300_bus_ctrl.sv
// tb_w5300_bus_ctrl: directed bench for w5300_bus_ctrl with default timing.
// Outputs are sampled on the falling clock edge; inputs are driven there too.
module tb_w5300_bus_ctrl;

    logic clk;
    logic rst_n;
    w5300_bus_ctrl_if bus();

    w5300_bus_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int overlap  = 0;

    // Minimal W5300 model: remembers what the last strobe presented.
    logic [9:0] cap_addr = '0;
    logic [7:0] cap_data = '0;
    logic       cap_rnw  = 1'b1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!bus.w_cs_n && !bus.w_wr_n) begin
            cap_addr <= bus.w_addr;
            cap_data <= bus.w_d_out;
            cap_rnw  <= 1'b0;
        end else if (!bus.w_cs_n && !bus.w_rd_n) begin
            cap_addr <= bus.w_addr;
            cap_rnw  <= 1'b1;
        end
    end

    // Illegal pin combinations: both strobes, strobe without chip select, drive during read.
    always @(negedge clk) begin
        if (!bus.w_rd_n && !bus.w_wr_n)                overlap <= overlap + 1;
        else if ((!bus.w_rd_n || !bus.w_wr_n) && bus.w_cs_n) overlap <= overlap + 1;
        else if (bus.w_d_oe && !bus.w_rd_n)            overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // One access from a single port; counts pin activity per cycle until the ack.
    task automatic run_txn(input bit port_b, input bit rnw, input logic [9:0] addr,
                           input logic [7:0] wd, output int ack_cyc, output int cs_lo,
                           output int rd_lo, output int wr_lo, output int oe_lo,
                           output int other_ack);
        @(negedge clk);
        if (port_b) begin
            bus.b_req = 1'b1; bus.b_rnw = rnw; bus.b_addr = addr; bus.b_wdata = wd;
        end else begin
            bus.a_req = 1'b1; bus.a_rnw = rnw; bus.a_addr = addr; bus.a_wdata = wd;
        end
        ack_cyc = -1; cs_lo = 0; rd_lo = 0; wr_lo = 0; oe_lo = 0; other_ack = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (!bus.w_cs_n) cs_lo++;
            if (!bus.w_rd_n) rd_lo++;
            if (!bus.w_wr_n) wr_lo++;
            if (bus.w_d_oe)  oe_lo++;
            if (port_b ? bus.a_ack : bus.b_ack) other_ack++;
            if (port_b ? bus.b_ack : bus.a_ack) begin
                ack_cyc = k;
                break;
            end
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
    endtask

    int exp_grant [4];
    int got, last_cyc, ack_cyc, cs_lo, rd_lo, wr_lo, oe_lo, other_ack, acks;

    initial begin
`ifdef W5300_BUS_CTRL_RR_EN
        exp_grant = '{0, 1, 0, 1};
`else
        exp_grant = '{0, 0, 0, 0};
`endif
        // Reset with both requesters already asking.
        rst_n = 1'b0;
        bus.a_req = 1'b1; bus.a_rnw = 1'b1; bus.a_addr = 10'h100; bus.a_wdata = 8'h00;
        bus.b_req = 1'b1; bus.b_rnw = 1'b0; bus.b_addr = 10'h200; bus.b_wdata = 8'hA5;
        bus.w_d_in = 8'h11;
        bus.w_int_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs_n",  bus.w_cs_n, 1);
        check("rst_rd_n",  bus.w_rd_n, 1);
        check("rst_wr_n",  bus.w_wr_n, 1);
        check("rst_d_oe",  bus.w_d_oe, 0);
        check("rst_addr",  bus.w_addr, 0);
        check("rst_d_out", bus.w_d_out, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_acks",  {bus.a_ack, bus.b_ack}, 0);
        check("rst_irq",   bus.irq, 0);

        // Both requests held continuously for four transactions.
        rst_n = 1'b1;
        last_cyc = 0;
        for (int t = 0; t < 4; t++) begin
            got = -1;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                if (bus.a_ack || bus.b_ack) begin
                    got = (bus.a_ack && bus.b_ack) ? 2 : (bus.b_ack ? 1 : 0);
                    if (t == 0) check("first_latency", k, 5);
                    break;
                end
            end
            check($sformatf("grant%0d", t), got, exp_grant[t]);
            if (t > 0) check($sformatf("period%0d", t), cyc - last_cyc, 6);
            last_cyc = cyc;
            if (t == 3) begin
                bus.a_req = 1'b0;
                bus.b_req = 1'b0;
            end
            @(negedge clk);
            check($sformatf("gap%0d", t), bus.w_cs_n, 1);
        end
        check("rdata_after_burst", bus.rdata, 8'h11);

        // Port A read from the top address.
        bus.w_d_in = 8'h5A;
        run_txn(1'b0, 1'b1, 10'h3FE, 8'h00, ack_cyc, cs_lo, rd_lo, wr_lo, oe_lo, other_ack);
        check("a_rd_ack_cyc", ack_cyc, 5);
        check("a_rd_cs_lo",   cs_lo, 5);
        check("a_rd_rd_lo",   rd_lo, 3);
        check("a_rd_wr_lo",   wr_lo, 0);
        check("a_rd_oe_lo",   oe_lo, 0);
        check("a_rd_b_ack",   other_ack, 0);
        check("a_rd_addr",    cap_addr, 10'h3FE);
        check("a_rd_rdata",   bus.rdata, 8'h5A);
        @(negedge clk);

        // Port B write; the data bus carries junk that must not reach rdata.
        bus.w_d_in = 8'hEE;
        run_txn(1'b1, 1'b0, 10'h012, 8'hC3, ack_cyc, cs_lo, rd_lo, wr_lo, oe_lo, other_ack);
        check("b_wr_ack_cyc", ack_cyc, 5);
        check("b_wr_wr_lo",   wr_lo, 3);
        check("b_wr_rd_lo",   rd_lo, 0);
        check("b_wr_oe_lo",   oe_lo, 5);
        check("b_wr_a_ack",   other_ack, 0);
        check("b_wr_cap_addr", cap_addr, 10'h012);
        check("b_wr_cap_data", cap_data, 8'hC3);
        check("b_wr_cap_rnw",  cap_rnw, 0);
        check("b_wr_rdata",    bus.rdata, 8'h5A);
        @(negedge clk);

        // Reset pulse in the middle of a write strobe.
        bus.a_req = 1'b1; bus.a_rnw = 1'b0; bus.a_addr = 10'h055; bus.a_wdata = 8'h77;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.a_ack || bus.b_ack) acks++;
        end
        check("abort_wr_low", bus.w_wr_n, 0);
        rst_n = 1'b0;
        bus.a_req = 1'b0;
        @(negedge clk);
        if (bus.a_ack || bus.b_ack) acks++;
        check("abort_wr_n", bus.w_wr_n, 1);
        check("abort_cs_n", bus.w_cs_n, 1);
        check("abort_d_oe", bus.w_d_oe, 0);
        check("abort_rdata", bus.rdata, 0);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.a_ack || bus.b_ack) acks++;
        end
        check("abort_no_ack", acks, 0);

        // Normal access after the aborted one.
        bus.w_d_in = 8'h5A;
        run_txn(1'b0, 1'b1, 10'h2AA, 8'h00, ack_cyc, cs_lo, rd_lo, wr_lo, oe_lo, other_ack);
        check("post_rst_ack_cyc", ack_cyc, 5);
        check("post_rst_rdata",   bus.rdata, 8'h5A);
        check("post_rst_addr",    cap_addr, 10'h2AA);

        // Interrupt synchroniser latency in both directions.
        @(negedge clk);
        bus.w_int_n = 1'b0;
        @(negedge clk);
        check("irq_rise_1", bus.irq, 0);
        @(negedge clk);
        check("irq_rise_2", bus.irq, 1);
        bus.w_int_n = 1'b1;
        @(negedge clk);
        check("irq_fall_1", bus.irq, 1);
        @(negedge clk);
        check("irq_fall_2", bus.irq, 0);

        check("pin_overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/w5300_bus_ctrl.md
# w5300_bus_ctrl

Bus sequencer for the W5300 Ethernet controller's 8-bit indirect/direct host port. Arbitrates between two internal requesters: port A (ZX CPU I/O decoder) and port B (internal housekeeping engine). Generates correctly timed `cs_n`/`rd_n`/`wr_n` strobes, drives and samples the shared data bus, and returns read data. Sits in the CPLD between the Z80 bus glue and the W5300 pins.

## Interface
Parameters:
- `SETUP_CYC`, 1, clocks with `cs_n` low and address stable before the strobe (≥1)
- `STROBE_CYC`, 3, clocks `rd_n`/`wr_n` held low (≥1)
- `HOLD_CYC`, 1, clocks `cs_n` low after the strobe rises (≥1)

Ports:
- `clk`  in  1  system clock; the only clock
- `rst_n`  in  1  synchronous active-low reset (sampled on rising `clk`)
- `a_req`, `b_req`  in  1  access request, held until the matching ack
- `a_rnw`, `b_rnw`  in  1  1 = read, 0 = write
- `a_addr`, `b_addr`  in  10  W5300 address
- `a_wdata`, `b_wdata`  in  8  write data
- `a_ack`, `b_ack`  out  1  one-cycle completion pulse
- `rdata`  out  8  last read data, shared by both ports
- `irq`  out  1  synchronised, active-high W5300 interrupt
- `w_addr`  out  10  W5300 address pins
- `w_cs_n`, `w_rd_n`, `w_wr_n`  out  1  W5300 strobes, active low
- `w_d_out`  out  8  data driven to W5300
- `w_d_oe`  out  1  tristate enable for `w_d_out`
- `w_d_in`  in  8  data bus input
- `w_int_n`  in  1  W5300 interrupt pin, asynchronous

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. A down-counter loads `SETUP_CYC-1`, `STROBE_CYC-1` or `HOLD_CYC-1` on entry to each state.
- IDLE: when any request is present, the winner's `rnw`/`addr`/`wdata` are latched and the FSM moves to SETUP. The grant is latched too.
- Arbitration is port A fixed-priority by default. See Configuration.
- SETUP: `w_cs_n`=0 and `w_addr`=latched address. For writes, `w_d_oe`=1.
- STROBE: `w_rd_n`=0 (read) or `w_wr_n`=0 (write). On the last STROBE cycle of a read, `w_d_in` is registered into `rdata`.
- HOLD: `w_cs_n` stays 0, strobes are 1, and `w_d_oe` stays 1 for writes. The granted ack is high during the last HOLD cycle. The next state is IDLE.
- `w_addr` and `w_d_out` hold their values until the next grant.
- `rdata` holds until the next read capture. Writes never alter it.
- `irq` = two-flop synchroniser of `~w_int_n`.
- A request dropped before its grant is ignored. A request dropped after its grant still completes, and the ack is still pulsed.
- Requester contract: if `req` is still high in the cycle after its ack, it is a new request.

## Timing
- Reset values: `w_cs_n`=`w_rd_n`=`w_wr_n`=1, `w_d_oe`=0, `w_addr`=0, `w_d_out`=0, `rdata`=0, acks=0, `irq`=0, state IDLE, RR pointer favours A.
- Latency: a request sampled in IDLE at edge E gives SETUP at cycle E+1. Ack comes in cycle E+`SETUP_CYC`+`STROBE_CYC`+`HOLD_CYC` (5 with defaults).
- At least one IDLE cycle with `w_cs_n`=1 between transactions. Back-to-back period = 1 + `SETUP_CYC` + `STROBE_CYC` + `HOLD_CYC` (6 with defaults).
- Strobes and `w_d_oe` are registered outputs: glitch-free and never low simultaneously.
- Reset asserted mid-transaction: all strobes go high and `w_d_oe`=0 at the next edge. No ack is issued, and the transaction is dropped.
- Simultaneous `a_req`/`b_req` in IDLE are resolved in that same cycle, with exactly one grant.

## Configuration
- `W5300_BUS_CTRL_RR_EN` defined: round-robin arbitration. On simultaneous requests the port not granted last wins. The pointer updates at grant time.
- Undefined: port A always wins simultaneous requests, and port B can be starved by continuous A traffic.

## Test plan
- Reset with `a_req` held: all outputs at reset values. After `rst_n`=1, the first grant goes to A.
- A read from 0x3FE with the W5300 model returning 0x5A (defaults):
  - `w_cs_n` is low 5 cycles and `w_rd_n` low 3 cycles.
  - `a_ack` pulses 5 cycles after the sample edge.
  - `rdata`=0x5A.
- B write 0xC3 to 0x012: the model captures addr 0x012, data 0xC3, rnw=0. `w_d_oe` is high for exactly 5 cycles, and `rdata` is unchanged.
- Both requests held continuously for 4 transactions:
  - with `W5300_BUS_CTRL_RR_EN`, grants go A,B,A,B;
  - without it, A,A,A,A;
  - always ≥1 cycle of `w_cs_n`=1 between transactions.
- `rst_n` pulsed low during STROBE of a write: `w_wr_n`=1 next edge, and no ack. A new request afterwards completes normally.
- `w_int_n` driven low: `irq` rises exactly 2 clocks later, and falls 2 clocks after `w_int_n` returns high.
